seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter WIDTH, default 8, is the maximum pattern length in bits.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-005 pattern  input  WIDTH  bits to transmit; only bits [len:0] are used.
REQ-006 len  input  clog2(WIDTH)  number of pattern bits minus one (0 means 1 bit, WIDTH-1 means WIDTH bits).
REQ-007 rep  input  2  extra repetitions of the pattern (0..3); total passes = rep+1.
REQ-008 x  output  1  serial data bit; driven 0 whenever x_valid is 0.
REQ-009 x_valid  output  1  high in every cycle in which x carries a pattern bit.
REQ-010 busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-011 done  output  1  one-cycle pulse after the last bit of the last pass.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: start=1 SHALL capture pattern, len and rep into internal registers and move to SHIFT; start=0 SHALL stay in IDLE.
REQ-014 Latency: the first bit SHALL appear on x, with x_valid=1, in the cycle immediately after start is sampled high.
REQ-015 Bit order SHALL be MSB-first within the used field: pattern[len], pattern[len-1], ..., pattern[0], one bit per cycle with no gaps.
REQ-016 Passes SHALL follow back-to-back: pattern[0] of pass k is followed, in the next cycle, by pattern[len] of pass k+1.
REQ-017 Total x_valid cycles per transmission SHALL equal (len+1)*(rep+1), from 1 up to 4*WIDTH.
REQ-018 After the last bit of the last pass, the FSM SHALL enter DONE for exactly one cycle (done=1, x_valid=0, x=0), then return to IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE; captured values SHALL NOT change mid-transmission when the pattern, len or rep inputs change.
REQ-020 A new start in the first IDLE cycle after DONE SHALL be accepted normally, giving a one-cycle idle gap between transmissions.
REQ-021 Internal counters SHALL be sized exactly: the bit index is clog2(WIDTH) bits and counts down from len to 0; the pass counter is 2 bits and counts down from rep to 0; neither wraps past 0 while in SHIFT.
REQ-022 len=0 and rep=0 SHALL produce a single valid bit followed by DONE.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE and clear x, x_valid, busy, done and all internal registers to 0, regardless of clk.
REQ-024 Reset asserted mid-transmission SHALL abort it with no further valid bits and no done pulse.
REQ-025 The first start sampled on the first rising edge after rst deasserts SHALL be accepted.

Structure
REQ-026 The state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and WIDTH SHALL live in the shared package seq_pkg.
REQ-027 One sub-module, seq_cnt, SHALL implement a loadable down-counter with a zero flag, with asynchronous active-high reset. It SHALL be instantiated twice: once as the bit index and once as the pass counter.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Verification
REQ-029 pattern=8'b1011_0110, len=7, rep=0, start pulsed at cycle 0 -> x=1,0,1,1,0,1,1,0 at cycles 1-8, done=1 at cycle 9, busy=1 for cycles 1-9.
REQ-030 pattern=8'bxxxx_x101, len=2, rep=2 -> x=1,0,1,1,0,1,1,0,1 at cycles 1-9 with x_valid continuous, done at cycle 10.
REQ-031 len=0, rep=0, pattern[0]=1 -> a single x=1 at cycle 1, done at cycle 2, IDLE at cycle 3.
REQ-032 start held high continuously with len=3, rep=0 -> second transmission's first bit at cycle 7 (DONE cycle 5, IDLE cycle 6); pattern changed during SHIFT has no effect.
REQ-033 rst pulsed asynchronously mid-cycle during bit 4 of an 8-bit transmission -> x, x_valid and busy go to 0 immediately, no done pulse; a later start transmits correctly from cycle 1.
REQ-034 rep=3, len=7 -> exactly 32 consecutive x_valid cycles followed by one done pulse.

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg : shared width and FSM state encoding for the seq_tx block. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_tx_if.sv
// ---------------------------------------------------------------------------
// seq_tx_if : request and serial-output bundle of seq_tx. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_tx_if;
  import seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [1:0]       rep;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, rep,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, rep,
    output x, x_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/seq_cnt.sv
// ---------------------------------------------------------------------------
// seq_cnt : loadable down-counter with zero flag; holds at zero. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_cnt #(
  parameter int W = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         load_i,
  input  wire logic [W-1:0] val_i,
  input  wire logic         dec_i,
  output logic      [W-1:0] cnt_o,
  output logic              zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/seq_tx.sv
// ---------------------------------------------------------------------------
// seq_tx : MSB-first serial transmitter of pattern[len:0], repeated rep+1 times. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_tx (
  input  wire logic clk,
  input  wire logic rst,
  seq_tx_if.slave   bus
);
  import seq_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_load, bit_dec, bit_zero;
  logic [LEN_W-1:0] bit_val, bit_cnt, bit_next;
  logic             pass_load, pass_dec, pass_zero;
  logic [1:0]       pass_cnt;

  // Bit index names the bit currently on x; the pass counter names passes still to come.
  seq_cnt #(.W(LEN_W)) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (bit_load),
    .val_i  (bit_val),
    .dec_i  (bit_dec),
    .cnt_o  (bit_cnt),
    .zero_o (bit_zero)
  );

  seq_cnt #(.W(2)) u_pass_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (pass_load),
    .val_i  (bus.rep),
    .dec_i  (pass_dec),
    .cnt_o  (pass_cnt),
    .zero_o (pass_zero)
  );

  assign bit_next = bit_cnt - 1'b1;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    x_d       = 1'b0;
    xv_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_load  = 1'b0;
    bit_val   = len_q;
    bit_dec   = 1'b0;
    pass_load = 1'b0;
    pass_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          // First bit is registered straight from the inputs so it appears one cycle after start.
          state_d   = SHIFT;
          pat_d     = bus.pattern;
          len_d     = bus.len;
          bit_load  = 1'b1;
          bit_val   = bus.len;
          pass_load = 1'b1;
          x_d       = bus.pattern[bus.len];
          xv_d      = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (!bit_zero) begin
          bit_dec = 1'b1;
          x_d     = pat_q[bit_next];
          xv_d    = 1'b1;
        end else if (!pass_zero) begin
          bit_load = 1'b1;
          pass_dec = |pass_cnt;
          x_d      = pat_q[len_q];
          xv_d     = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = xv_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_tx : queue-based reference model plus literal checkpoints for seq_tx. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_tx;
  import seq_pkg::*;

  typedef struct packed {
    logic x;
    logic xv;
    logic busy;
    logic done;
  } obs_t;

  logic clk;
  logic rst;

  seq_tx_if bus ();

  seq_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model: every accepted start expands into its full per-cycle output stream.
  obs_t exp_q[$];
  obs_t cur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      cur = '0;
    end else begin
      if (!cur.busy && bus.start) begin
        for (int p = 0; p <= int'(bus.rep); p++) begin
          for (int i = int'(bus.len); i >= 0; i--) begin
            exp_q.push_back('{x: bus.pattern[i], xv: 1'b1, busy: 1'b1, done: 1'b0});
          end
        end
        exp_q.push_back('{x: 1'b0, xv: 1'b0, busy: 1'b1, done: 1'b1});
      end
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    end
  end

  logic lit_en;
  logic lit_chkx;
  obs_t lit;

  always @(negedge clk) begin : checker_blk
    logic [3:0] act;
    logic [3:0] want;
    act = {bus.x, bus.x_valid, bus.busy, bus.done};
    n_cmp++;
    if (act !== cur) begin
      n_fail++;
      $display("FAIL model t=%0t x/xv/busy/done got %b required %b", $time, act, cur);
    end
    if (lit_en) begin
      want = lit;
      if (!lit_chkx) want[3] = act[3];
      n_cmp++;
      if (act !== want) begin
        n_fail++;
        $display("FAIL literal t=%0t x/xv/busy/done got %b required %b", $time, act, want);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic expect_cyc(input logic ex, input logic exv, input logic eb,
                            input logic ed, input logic chkx = 1'b1);
    lit      = '{x: ex, xv: exv, busy: eb, done: ed};
    lit_chkx = chkx;
    lit_en   = 1'b1;
  endtask

  task automatic launch(input logic [7:0] pat, input logic [2:0] l, input logic [1:0] r);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = l;
    bus.rep     = r;
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] seq_a;
    logic [8:0] seq_b;
    lit_en      = 1'b0;
    lit_chkx    = 1'b1;
    lit         = '0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.rep     = '0;

    tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Start offered on the first edge after reset release.
    rst   = 1'b0;
    seq_a = 8'b1011_0110;
    launch(8'b1011_0110, 3'd7, 2'd0);
    for (int i = 0; i < 8; i++) begin
      expect_cyc(seq_a[7-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_cyc(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Three passes of a 3-bit field with junk above it.
    seq_b = 9'b101_101_101;
    launch(8'b1010_1101, 3'd2, 2'd2);
    for (int i = 0; i < 9; i++) begin
      expect_cyc(seq_b[8-i], 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_cyc(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Single-bit transmission.
    launch(8'h55, 3'd0, 2'd0);
    expect_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    expect_cyc(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // start held high; pattern changed mid-transmission only affects the next one.
    launch(8'h0A, 3'd3, 2'd0);
    bus.start = 1'b1;
    expect_cyc(1'b1, 1'b1, 1'b1, 1'b0); tick();
    bus.pattern = 8'h05;
    expect_cyc(1'b0, 1'b1, 1'b1, 1'b0); tick();
    expect_cyc(1'b1, 1'b1, 1'b1, 1'b0); tick();
    expect_cyc(1'b0, 1'b1, 1'b1, 1'b0); tick();
    expect_cyc(1'b0, 1'b0, 1'b1, 1'b1); tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0); tick();
    expect_cyc(1'b0, 1'b1, 1'b1, 1'b0); tick();
    bus.start = 1'b0;
    expect_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (6) tick();

    // Asynchronous reset during bit 4 of an 8-bit transmission.
    launch(8'hFF, 3'd7, 2'd0);
    repeat (3) tick();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    launch(8'b1100_1010, 3'd7, 2'd0);
    expect_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (11) tick();

    // Longest transmission: 32 valid bits then done.
    launch(8'($urandom), 3'd7, 2'd3);
    for (int i = 0; i < 32; i++) begin
      expect_cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    expect_cyc(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Random traffic with occasional mid-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.pattern = 8'($urandom);
      bus.len     = 3'($urandom);
      bus.rep     = 2'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
